// File: rtl/touch_adc_pkg.sv
// Shared constants, register addresses and state encodings for the touch-panel ADC scanner.
package touch_adc_pkg;

  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  localparam int FRAME_BITS      = 24;
  localparam int DATA_FIRST_EDGE = 9;
  localparam int DATA_BITS       = 12;

  localparam logic [1:0] ADDR_COORD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_X,
    ST_CONV_Y,
    ST_PUBLISH,
    ST_GAP
  } scan_state_t;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_LOW,
    SPI_HIGH,
    SPI_TRAIL,
    SPI_GAP
  } spi_phase_t;

endpackage

// File: rtl/touch_adc_spi_xfer.sv
// One 24-SCLK ADS7843 frame per start pulse; done pulses after cs_n has been high 2*CLK_DIV cycles.
// start is only honoured while idle; the caller waits for done before the next frame.
module touch_adc_spi_xfer
  import touch_adc_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  output logic        done,
  output logic [11:0] result,
  output logic        cs_n,
  output logic        sclk,
  output logic        din,
  input  logic        dout
);

  localparam logic [8:0] HALF       = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP        = 9'(2 * CLK_DIV - 1);
  localparam logic [4:0] LAST_EDGE  = 5'(FRAME_BITS - 1);
  localparam logic [4:0] FIRST_DATA = 5'(DATA_FIRST_EDGE);
  localparam logic [4:0] LAST_DATA  = 5'(DATA_FIRST_EDGE + DATA_BITS - 1);

  spi_phase_t  phase;
  logic [8:0]  div_cnt;
  logic [4:0]  edge_cnt;
  logic [6:0]  cmd_sh;
  logic [11:0] data_sh;
  logic        tick;

  assign tick = (div_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= SPI_IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      cmd_sh   <= '0;
      data_sh  <= '0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      din      <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (phase)
        SPI_IDLE: if (start) begin
          cs_n     <= 1'b0;
          din      <= cmd[7];
          cmd_sh   <= cmd[6:0];
          edge_cnt <= '0;
          div_cnt  <= HALF;
          phase    <= SPI_LOW;
        end
        SPI_LOW: if (tick) begin
          sclk    <= 1'b1;
          div_cnt <= HALF;
          phase   <= SPI_HIGH;
          if (edge_cnt >= FIRST_DATA && edge_cnt <= LAST_DATA)
            data_sh <= {data_sh[10:0], dout};
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
        SPI_HIGH: if (tick) begin
          // Command drains MSB first; once empty, din rests at 0 for the rest of the frame.
          sclk     <= 1'b0;
          div_cnt  <= HALF;
          edge_cnt <= edge_cnt + 1'b1;
          din      <= cmd_sh[6];
          cmd_sh   <= {cmd_sh[5:0], 1'b0};
          phase    <= (edge_cnt == LAST_EDGE) ? SPI_TRAIL : SPI_LOW;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
        SPI_TRAIL: if (tick) begin
          cs_n    <= 1'b1;
          div_cnt <= GAP;
          phase   <= SPI_GAP;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
        SPI_GAP: if (tick) begin
          done   <= 1'b1;
          result <= data_sh;
          phase  <= SPI_IDLE;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
        default: phase <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/touch_panel_adc_scanner.sv
// Pen-irq debounce plus periodic X/Y SPI scan published on a 4-word Avalon-MM slave (1-cycle reads).
// TOUCH_AVERAGE4_EN: publish the truncated mean of 4 back-to-back X/Y pairs instead of a single pair.
module touch_panel_adc_scanner
  import touch_adc_pkg::*;
#(
  parameter int CLK_DIV         = 25,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_GAP        = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        pen_irq_n,
  output logic        pen_irq_filt_n,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout
);

  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(SCAN_GAP - 1);

  logic        pen_s1, pen_s2, pen_filt, pen_down;
  logic [31:0] db_cnt;
  scan_state_t state;
  logic        spi_start, spi_done;
  logic [7:0]  spi_cmd;
  logic [11:0] spi_result, x_smp, pub_x, pub_y;
  logic [31:0] gap_cnt;
  logic        pub_ok, publish, busy, wr_en, rd_en, coord_wr;
  logic        valid, overrun, irq_mask, scan_en;
  logic [11:0] coord_x, coord_y;
  logic [31:0] rd_mux;
  logic        unused_wdata;
`ifdef TOUCH_AVERAGE4_EN
  logic [1:0]  pair_cnt;
  logic [13:0] sum_x, sum_y;
  logic        pen_lost;
  logic        unused_frac;
`else
  logic [11:0] y_smp;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_s1   <= 1'b1;
      pen_s2   <= 1'b1;
      pen_filt <= 1'b1;
      db_cnt   <= '0;
    end else begin
      pen_s1 <= pen_irq_n;
      pen_s2 <= pen_s1;
      if (pen_s2 == pen_filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        pen_filt <= pen_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign pen_irq_filt_n = pen_filt;
  assign pen_down       = ~pen_filt;

  touch_adc_spi_xfer #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (spi_start),
    .cmd    (spi_cmd),
    .done   (spi_done),
    .result (spi_result),
    .cs_n   (adc_cs_n),
    .sclk   (adc_sclk),
    .din    (adc_din),
    .dout   (adc_dout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      spi_start <= 1'b0;
      spi_cmd   <= '0;
      x_smp     <= '0;
      gap_cnt   <= '0;
`ifdef TOUCH_AVERAGE4_EN
      pair_cnt  <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
      pen_lost  <= 1'b0;
`else
      y_smp     <= '0;
`endif
    end else begin
      spi_start <= 1'b0;
`ifdef TOUCH_AVERAGE4_EN
      if (state == ST_CONV_X || state == ST_CONV_Y)
        pen_lost <= pen_lost | ~pen_down;
`endif
      case (state)
        ST_IDLE: if (scan_en && pen_down) begin
          state     <= ST_CONV_X;
          spi_start <= 1'b1;
          spi_cmd   <= CMD_X;
        end
        ST_CONV_X: if (spi_done) begin
          x_smp     <= spi_result;
          state     <= ST_CONV_Y;
          spi_start <= 1'b1;
          spi_cmd   <= CMD_Y;
        end
        ST_CONV_Y: if (spi_done) begin
`ifdef TOUCH_AVERAGE4_EN
          // Pairs run back to back; scan_en and pen state only matter at publish/gap time.
          sum_x    <= sum_x + {2'b00, x_smp};
          sum_y    <= sum_y + {2'b00, spi_result};
          pair_cnt <= pair_cnt + 1'b1;
          if (pair_cnt == 2'd3) begin
            state <= ST_PUBLISH;
          end else begin
            state     <= ST_CONV_X;
            spi_start <= 1'b1;
            spi_cmd   <= CMD_X;
          end
`else
          y_smp <= spi_result;
          state <= ST_PUBLISH;
`endif
        end
        ST_PUBLISH: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
`ifdef TOUCH_AVERAGE4_EN
          sum_x    <= '0;
          sum_y    <= '0;
          pen_lost <= 1'b0;
`endif
        end
        ST_GAP: if (gap_cnt == GAP_LAST) begin
          if (scan_en && pen_down) begin
            state     <= ST_CONV_X;
            spi_start <= 1'b1;
            spi_cmd   <= CMD_X;
          end else begin
            state <= ST_IDLE;
          end
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TOUCH_AVERAGE4_EN
  assign pub_x       = sum_x[13:2];
  assign pub_y       = sum_y[13:2];
  assign pub_ok      = pen_down & ~pen_lost;
  assign unused_frac = ^{sum_x[1:0], sum_y[1:0]};
`else
  assign pub_x  = x_smp;
  assign pub_y  = y_smp;
  assign pub_ok = pen_down;
`endif

  assign publish      = (state == ST_PUBLISH) && pub_ok;
  assign busy         = (state != ST_IDLE) && (state != ST_GAP);
  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & write_n;
  assign coord_wr     = wr_en && (address == ADDR_COORD);
  assign unused_wdata = ^writedata[31:1];
  assign irq          = valid & irq_mask;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_COORD:    rd_mux = {valid, 3'b000, coord_y, 4'b0000, coord_x};
      ADDR_STATUS:   rd_mux = {29'd0, overrun, busy, pen_down};
      ADDR_IRQ_MASK: rd_mux = {31'd0, irq_mask};
      ADDR_CTRL:     rd_mux = {31'd0, scan_en};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      overrun  <= 1'b0;
      coord_x  <= '0;
      coord_y  <= '0;
      irq_mask <= 1'b0;
      scan_en  <= 1'b0;
      readdata <= '0;
    end else begin
      if (coord_wr) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[0];
      if (wr_en && address == ADDR_CTRL)     scan_en  <= writedata[0];
      // A same-cycle COORD write clears overrun but the fresh sample still lands as valid.
      if (publish) begin
        coord_x <= pub_x;
        coord_y <= pub_y;
        valid   <= 1'b1;
        if (valid && !coord_wr) overrun <= 1'b1;
      end
      if (rd_en) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_touch_panel_adc_scanner.sv
// Randomised bench for touch_panel_adc_scanner with a behavioural ADS7843 model and coordinate reference.
module tb_touch_panel_adc_scanner;
  import touch_adc_pkg::*;

  localparam int CLK_DIV         = 6;
  localparam int DEBOUNCE_CYCLES = 200;
  localparam int SCAN_GAP        = 300;
`ifdef TOUCH_AVERAGE4_EN
  localparam int PAIRS = 4;
`else
  localparam int PAIRS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        pen_irq_n = 1'b1;
  logic        pen_irq_filt_n;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;

  always #5 clk = ~clk;

  touch_panel_adc_scanner #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SCAN_GAP(SCAN_GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .pen_irq_n(pen_irq_n), .pen_irq_filt_n(pen_irq_filt_n), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural ADC: captures the command on rises 0..7, answers on rises 9..20.
  int         rise_cnt = 0;
  int         frames_started = 0;
  int         filt_edges = 0;
  logic [7:0] cmd_sh = '0;
  logic [7:0] exp_cmd = 8'hD0;
  logic [11:0] cur_data = '0;
  bit         mon_en = 1'b0;
  bit         abort_frame = 1'b0;
  int         q_x[$], q_y[$], force_x[$], force_y[$];

  always @(negedge adc_cs_n) begin
    rise_cnt = 0;
    cmd_sh   = '0;
    cur_data = '0;
    adc_dout = 1'b0;
    frames_started++;
  end

  always @(posedge adc_sclk) begin
    if (rise_cnt < 8) cmd_sh = {cmd_sh[6:0], adc_din};
    if (rise_cnt == 7) begin
      if (cmd_sh == CMD_X) begin
        cur_data = (force_x.size() > 0) ? 12'(force_x.pop_front()) : 12'($urandom_range(0, 4095));
        q_x.push_back(int'(cur_data));
      end else if (cmd_sh == CMD_Y) begin
        cur_data = (force_y.size() > 0) ? 12'(force_y.pop_front()) : 12'($urandom_range(0, 4095));
        q_y.push_back(int'(cur_data));
      end else begin
        cur_data = '0;
      end
    end
    rise_cnt++;
  end

  always @(negedge adc_sclk) begin
    if (rise_cnt >= 9 && rise_cnt <= 20) adc_dout = cur_data[20 - rise_cnt];
    else adc_dout = 1'b0;
  end

  always @(posedge adc_cs_n) begin
    if (abort_frame || !mon_en) begin
      abort_frame = 1'b0;
      exp_cmd     = CMD_X;
    end else begin
      check_eq("frame_sclk_rises", rise_cnt, FRAME_BITS);
      check_eq("frame_cmd", {24'd0, cmd_sh}, {24'd0, exp_cmd});
      exp_cmd = (cmd_sh == CMD_X) ? CMD_Y : CMD_X;
    end
  end

  always @(negedge pen_irq_filt_n) filt_edges++;

  // Expected COORD word: mean (truncating) of the last PAIRS samples, valid set.
  function automatic logic [31:0] model_coord();
    int sx = 0;
    int sy = 0;
    for (int i = 0; i < PAIRS; i++) begin
      sx += q_x[q_x.size() - 1 - i];
      sy += q_y[q_y.size() - 1 - i];
    end
    sx = sx / PAIRS;
    sy = sy / PAIRS;
    return 32'h8000_0000 | (32'(sy) << 16) | 32'(sx);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic wait_frames(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (frames_started >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("frame_start_timeout", ok, 1);
  endtask

  task automatic wait_not_busy();
    logic [31:0] d;
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      av_read(ADDR_STATUS, d);
      if (!d[1]) begin ok = 1'b1; break; end
    end
    check_eq("busy_timeout", ok, 1);
  endtask

  // Enable just long enough to launch one publish cycle, then let it settle back to idle.
  task automatic run_one_scan();
    int fs;
    fs = frames_started;
    av_write(ADDR_CTRL, 32'd1);
    wait_frames(fs + 1);
    av_write(ADDR_CTRL, 32'd0);
    wait_not_busy();
    tick(SCAN_GAP + 20);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int t, fs, e0;
    bit ok;

    #2 reset_n = 1'b0;
    #18;
    check_eq("rst_readdata", readdata, 0);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_filt", pen_irq_filt_n, 1);
    check_eq("rst_cs_n", adc_cs_n, 1);
    check_eq("rst_sclk", adc_sclk, 0);
    check_eq("rst_din", adc_din, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    for (int a = 0; a < 4; a++) begin
      av_read(2'(a), d);
      check_eq($sformatf("rst_reg%0d", a), d, 0);
    end

    // Debounce with a 10-cycle glitch part way through the settle window.
    e0 = filt_edges;
    @(negedge clk) pen_irq_n = 1'b0;
    tick(120);
    pen_irq_n = 1'b1;
    tick(10);
    pen_irq_n = 1'b0;
    t = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); t++;
      if (!pen_irq_filt_n) begin ok = 1'b1; break; end
    end
    check_eq("db_fell", ok, 1);
    check_eq("db_latency_window", (t >= DEBOUNCE_CYCLES && t <= DEBOUNCE_CYCLES + 6), 1);
    tick(50);
    check_eq("db_single_fall", filt_edges - e0, 1);
    av_read(ADDR_STATUS, d);
    check_eq("status_pen_down", d, 32'd1);

    // Fixed coordinate pair.
    repeat (PAIRS) begin force_x.push_back(12'hA5C); force_y.push_back(12'h3F1); end
    run_one_scan();
    av_read(ADDR_COORD, d);
    check_eq("coord_fixed", d, 32'h83F1_0A5C);
    check_eq("coord_fixed_model", d, model_coord());
    check_eq("irq_masked", irq, 0);

    // Interrupt, clear and overrun.
    av_write(ADDR_IRQ_MASK, 32'd1);
    av_read(ADDR_IRQ_MASK, d);
    check_eq("irq_mask_rb", d, 32'd1);
    check_eq("irq_set", irq, 1);
    av_write(ADDR_COORD, 32'hFFFF_FFFF);
    check_eq("irq_cleared", irq, 0);
    av_read(ADDR_COORD, d);
    check_eq("coord_valid_cleared", d[31], 0);
    run_one_scan();
    run_one_scan();
    av_read(ADDR_STATUS, d);
    check_eq("status_overrun", d, 32'd5);
    av_read(ADDR_COORD, d);
    check_eq("coord_overwrite", d, model_coord());
    av_write(ADDR_COORD, 32'd0);
    av_read(ADDR_STATUS, d);
    check_eq("status_overrun_clr", d, 32'd1);

    // Random pairs.
    for (int k = 0; k < 3; k++) begin
      run_one_scan();
      av_read(ADDR_COORD, d);
      check_eq($sformatf("coord_rand%0d", k), d, model_coord());
      check_eq($sformatf("irq_rand%0d", k), irq, 1);
      av_write(ADDR_COORD, 32'd0);
      check_eq($sformatf("irq_rand_clr%0d", k), irq, 0);
    end

    // Pen lifted during the Y frame: frame completes, nothing published, scanner idles.
    fs = frames_started;
    av_write(ADDR_CTRL, 32'd1);
    wait_frames(fs + 2);
    tick(20);
    pen_irq_n = 1'b1;
    wait_not_busy();
    tick(SCAN_GAP + 20);
    fs = frames_started;
    tick(SCAN_GAP + 100);
    check_eq("penup_no_rescan", frames_started, fs);
    av_read(ADDR_COORD, d);
    check_eq("penup_valid", d[31], 0);
    av_read(ADDR_STATUS, d);
    check_eq("penup_status", d, 0);
    av_write(ADDR_CTRL, 32'd0);

    // Asynchronous reset in the middle of a frame.
    pen_irq_n = 1'b0;
    tick(DEBOUNCE_CYCLES + 20);
    fs = frames_started;
    av_write(ADDR_CTRL, 32'd1);
    wait_frames(fs + 1);
    av_read(ADDR_STATUS, d);
    check_eq("status_busy_pen", d, 32'd3);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rise_cnt >= 12) begin ok = 1'b1; break; end
    end
    check_eq("reach_bit12", ok, 1);
    #1;
    abort_frame = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("arst_cs_n", adc_cs_n, 1);
    check_eq("arst_sclk", adc_sclk, 0);
    check_eq("arst_readdata", readdata, 0);
    tick(3);
    reset_n = 1'b1;
    av_read(ADDR_CTRL, d);
    check_eq("arst_ctrl", d, 0);
    check_eq("arst_filt", pen_irq_filt_n, 1);
    tick(DEBOUNCE_CYCLES + 20);
    run_one_scan();
    av_read(ADDR_COORD, d);
    check_eq("coord_after_reset", d, model_coord());

`ifdef TOUCH_AVERAGE4_EN
    av_write(ADDR_COORD, 32'd0);
    force_x.push_back(100); force_x.push_back(101); force_x.push_back(102); force_x.push_back(104);
    force_y.push_back(4000); force_y.push_back(4001); force_y.push_back(4002); force_y.push_back(4003);
    run_one_scan();
    av_read(ADDR_COORD, d);
    check_eq("avg_x", {20'd0, d[11:0]}, 32'd101);
    check_eq("avg_y", {20'd0, d[27:16]}, 32'd4001);
    check_eq("avg_model", d, model_coord());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
